mux_sel_arb: RTL

Synchronous arbiter and sequencer for the select input of a shared 2:1 `mux` cell in the analog_core CPU models. Two requesters compete for the mux output path. The block grants one at a time with round-robin fairness. Before handing the path to the other input, it inserts guard cycles after every `sel` change, so the behavioural mux delay and jitter settle before the new owner uses the output.

---
 rtl/mux_sel_arb_if.sv | 29 ++
 rtl/mux_sel_arb.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mux_sel_arb_if.sv
// rtl/mux_sel_arb_if.sv - request/grant/select bundle between requesters and mux_sel_arb
interface mux_sel_arb_if;
    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;
    logic sel;
    logic busy;

    // Requester side: raises requests, observes grants and the mux select
    modport master (
        output req0,
        output req1,
        input  gnt0,
        input  gnt1,
        input  sel,
        input  busy
    );

    // Arbiter side
    modport slave (
        input  req0,
        input  req1,
        output gnt0,
        output gnt1,
        output sel,
        output busy
    );
endinterface

// File: rtl/mux_sel_arb.sv
// rtl/mux_sel_arb.sv - round-robin arbiter driving a shared 2:1 mux select with guard cycles (optional MUX_SEL_ARB_MAX_HOLD_EN)
module mux_sel_arb #(
    parameter int GUARD_CYCLES = 2,
    parameter int MAX_HOLD     = 16
) (
    input  logic          clk,
    input  logic          rst,
    mux_sel_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GUARD  = 2'd1,
        ST_GRANT0 = 2'd2,
        ST_GRANT1 = 2'd3
    } state_t;

    // Out-of-range parameters are rejected while elaborating
    if (GUARD_CYCLES < 0 || GUARD_CYCLES > 15 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_check
        $error("mux_sel_arb: GUARD_CYCLES must be 0..15 and MAX_HOLD 1..255");
    end

    // Guard counter load value; only used when GUARD_CYCLES is non-zero
    localparam int          GUARD_INIT_I = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;
    localparam logic [3:0]  GUARD_INIT   = GUARD_INIT_I[3:0];
    localparam bit          NO_GUARD     = (GUARD_CYCLES == 0);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_sel;
    logic        w_sel_next;
    logic        r_prio;
    logic        w_prio_next;
    logic [3:0]  r_guard_cnt;
    logic [3:0]  w_guard_next;

    logic        w_any_req;
    logic        w_win;
    logic        w_req_sel;
    logic        w_hold_done;

    // Winner selection: a lone request wins outright, a tie goes to the priority pointer
    always_comb begin
        w_any_req = bus.req0 | bus.req1;
        w_win     = r_prio;
        if (bus.req0 && !bus.req1) begin
            w_win = 1'b0;
        end else if (bus.req1 && !bus.req0) begin
            w_win = 1'b1;
        end
        w_req_sel = r_sel ? bus.req1 : bus.req0;
    end

`ifdef MUX_SEL_ARB_MAX_HOLD_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    logic [7:0]  r_hold_cnt;
    logic [7:0]  w_hold_inc;
    logic        w_in_grant;
    logic        w_other_req;

    // Hold counter: the value it takes at the end of this grant cycle, saturating at the limit;
    // the hand-over decision uses this value so the owner keeps exactly MAX_HOLD cycles
    always_comb begin
        w_in_grant  = (r_state == ST_GRANT0) || (r_state == ST_GRANT1);
        w_other_req = (r_state == ST_GRANT0) ? bus.req1 : bus.req0;
        w_hold_inc  = (r_hold_cnt >= HOLD_LIMIT) ? HOLD_LIMIT : r_hold_cnt + 8'd1;
        w_hold_done = w_in_grant && w_other_req && (w_hold_inc == HOLD_LIMIT);
    end

    // Hold counter register: zero outside GRANT, so every grant starts from zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= 8'd0;
        end else if (!w_in_grant || w_state_next == ST_IDLE) begin
            r_hold_cnt <= 8'd0;
        end else begin
            r_hold_cnt <= w_hold_inc;
        end
    end
`else
    // Without the hold limit a grant lasts until the owner releases it
    assign w_hold_done = 1'b0;
`endif

    // Next-state logic for state, select, priority pointer and guard counter
    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_prio_next  = r_prio;
        w_guard_next = r_guard_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_sel_next = w_win;
                    if ((w_win == r_sel) || NO_GUARD) begin
                        w_state_next = w_win ? ST_GRANT1 : ST_GRANT0;
                    end else begin
                        w_state_next = ST_GUARD;
                        w_guard_next = GUARD_INIT;
                    end
                end
            end

            ST_GUARD: begin
                if (!w_req_sel) begin
                    // Requester gave up while the mux settled: select stays switched,
                    // priority is untouched
                    w_state_next = ST_IDLE;
                end else if (r_guard_cnt == 4'd0) begin
                    w_state_next = r_sel ? ST_GRANT1 : ST_GRANT0;
                end else begin
                    w_guard_next = r_guard_cnt - 4'd1;
                end
            end

            ST_GRANT0: begin
                if (!bus.req0 || w_hold_done) begin
                    w_state_next = ST_IDLE;
                    w_prio_next  = 1'b1;
                end
            end

            ST_GRANT1: begin
                if (!bus.req1 || w_hold_done) begin
                    w_state_next = ST_IDLE;
                    w_prio_next  = 1'b0;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, select, priority and guard registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sel       <= 1'b0;
            r_prio      <= 1'b0;
            r_guard_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_next;
            r_sel       <= w_sel_next;
            r_prio      <= w_prio_next;
            r_guard_cnt <= w_guard_next;
        end
    end

    // Grants and busy decode from the registered state only, so they cannot glitch
    assign bus.gnt0 = (r_state == ST_GRANT0);
    assign bus.gnt1 = (r_state == ST_GRANT1);
    assign bus.busy = (r_state != ST_IDLE);
    assign bus.sel  = r_sel;

endmodule
